muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Iterative controller for the M-extension ops of `ALU_op_t`: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU. It sits beside the single-cycle ALU in the execute stage. It accepts one operation at a time, holds the pipeline via `busy`, and returns a 32-bit result with a one-cycle `done` pulse. It uses one 32-bit adder/subtractor, shared between shift-add multiply and restoring divide.

## Interface
- `XLEN`, default 32: operand/result width. Only 32 is supported. Iteration count equals `XLEN`.
- `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `rst`: input, 1 bit. Synchronous, active-high reset. Has priority over every other input.
- `start`: input, 1 bit. Request, sampled only while `busy`=0.
- `op`: input, `ALU_op_t` (from `alu_op_pkg`). Operation, captured on accept.
- `a`: input, XLEN. rs1 operand, captured on accept.
- `b`: input, XLEN. rs2 operand, captured on accept.
- `flush`: input, 1 bit. Synchronous abort of the in-flight operation.
- `busy`: output, 1 bit. High from the cycle after accept until the cycle `done` is high, inclusive.
- `done`: output, 1 bit. One-cycle pulse; `result` is valid in this cycle.
- `result`: output, XLEN. Final value. Held until the next accept.

## Operation
- FSM states:
  - IDLE → CALC on accept (`start`=1, `busy`=0, `op` in the M set).
  - IDLE → DONE on accept of a special case.
  - CALC → FIX after `XLEN` iterations.
  - FIX → DONE.
  - DONE → IDLE.
- `start` with a non-M op (NOP, ADD … AND) is ignored; the FSM stays in IDLE.
- `start` while `busy`=1 is ignored; no queueing.
- Sign prep on accept:
  - Operands are converted to magnitudes according to op signedness. MUL/MULH/DIV/REM treat a and b as signed. MULHSU treats a as signed, b as unsigned. MULHU/DIVU/REMU treat both as unsigned.
  - A negate flag is recorded.
- Multiply: 64-bit shift-add over 32 iterations, one multiplier bit per cycle.
  - FIX negates the 64-bit product if the flag is set.
  - MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
- Divide: restoring, one quotient bit per cycle.
  - FIX negates the quotient if the operand signs differ.
  - FIX gives the remainder the dividend's sign.
- Special cases (detected at accept; no iteration):
  - b=0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → a.
  - DIV with a=0x80000000, b=0xFFFFFFFF → 0x80000000; REM with the same operands → 0.
- `flush`=1 in any non-IDLE state → IDLE on the next edge. No `done` is produced; `result` keeps its old value. `flush` in IDLE has no effect and does not block a same-cycle `start`.
- `rst` mid-operation: returns to IDLE and clears all outputs and datapath registers; no `done`.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0; FSM in IDLE.
- Cycle 0 is the cycle in which `start` is accepted.
- Normal op: CALC occupies cycles 1–32, FIX cycle 33; `done`=1 and `result` valid in cycle 34. `busy`=1 in cycles 1–34.
- Special case: `done`=1 in cycle 1; `busy`=1 in cycle 1 only.
- A new `start` may be accepted in the cycle after `done` (IDLE). It is not accepted in the `done` cycle itself.
- `flush` and `done` cannot coincide in a way that drops a result: a `flush` in the DONE cycle still lets `done` fire and only prevents nothing further.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - Multiply ops use a combinational signed 33×33 product, registered into the FIX stage.
  - CALC is skipped for multiplies; `done` comes in cycle 2 and `busy` is high in cycles 1–2.
  - Division is unchanged.
- `MULDIV_FAST_MUL_EN` undefined: all ops use the shared iterative datapath with the timing above. No hardware multiplier is inferred.

## Test plan
- MUL a=7, b=0xFFFFFFFD (−3) → `result`=0xFFFFFFEB, `done` in cycle 34 (cycle 2 with the fast-mul macro), `busy` high in cycles 1–34.
- a=b=0xFFFFFFFF:
  - MULHU → 0xFFFFFFFE.
  - MULH → 0x00000000.
  - MULHSU → 0xFFFFFFFF.
- Signed divide, a=0xFFFFFFF9 (−7), b=2:
  - DIV → 0xFFFFFFFD.
  - REM → 0xFFFFFFFF.
- DIVU a=0xFFFFFFFF, b=0x10 → 0x0FFFFFFF; REMU → 0xF.
- Special cases:
  - DIVU 5/0 → 0xFFFFFFFF, `done` in cycle 1.
  - REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM with the same operands → 0.
- Abort and reset:
  - MUL started, `flush` in cycle 10 → `busy`=0 in cycle 11, no `done` pulse, `result` unchanged.
  - `start` with ADD, or during `busy` → ignored.
  - `rst` in cycle 20 → all outputs 0 next cycle.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Iterative M-extension multiply/divide sequencer sharing one adder/subtractor.
// Optional macro MULDIV_FAST_MUL_EN: single-cycle multiply product, divide unchanged.
package alu_op_pkg;
  typedef enum logic [4:0] {
    NOP, ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
    MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
  } ALU_op_t;
endpackage

module muldiv_sequencer
  import alu_op_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  ALU_op_t         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CntW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t          state_q, state_d;
  ALU_op_t         op_q, op_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, bMag_q, bMag_d, result_q, result_d;
  logic            negQ_q, negQ_d, negR_q, negR_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            isM, isDivOp, isDivQ, aSigned, bSigned, aNeg, bNeg;
  logic            bZero, ovf, special;
  logic [XLEN-1:0] aMag, bMag, specVal, hiNew;
  logic [XLEN+1:0] addA, sum;
  logic [2*XLEN-1:0] prodFix;
  logic            carry;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fa, fb, fastProd;
`endif

  always_comb begin
    isM     = op inside {MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU};
    isDivOp = op inside {DIV, DIVU, REM, REMU};
    isDivQ  = op_q inside {DIV, DIVU, REM, REMU};
    aSigned = op inside {MUL, MULH, MULHSU, DIV, REM};
    bSigned = op inside {MUL, MULH, DIV, REM};
    aNeg    = aSigned & a[XLEN-1];
    bNeg    = bSigned & b[XLEN-1];
    aMag    = aNeg ? -a : a;
    bMag    = bNeg ? -b : b;
    bZero   = (b == '0);
    ovf     = (op inside {DIV, REM}) && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    special = isDivOp && (bZero || ovf);
    if (bZero) specVal = (op inside {REM, REMU}) ? a : '1;
    else       specVal = (op == REM) ? '0 : a;
`ifdef MULDIV_FAST_MUL_EN
    fa       = {{XLEN{aNeg}}, a};
    fb       = {{XLEN{bNeg}}, b};
    fastProd = fa * fb;
`endif
    // Divide subtracts divisor from the shifted partial remainder; multiply adds the multiplicand.
    addA    = isDivQ ? {1'b0, hi_q, lo_q[XLEN-1]} : {2'b00, hi_q};
    sum     = isDivQ ? (addA - {2'b00, bMag_q}) : (addA + {2'b00, bMag_q});
    carry   = lo_q[0] ? sum[XLEN] : 1'b0;
    hiNew   = lo_q[0] ? sum[XLEN-1:0] : hi_q;
    prodFix = negQ_q ? -{hi_q, lo_q} : {hi_q, lo_q};
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    bMag_d   = bMag_q;
    negQ_d   = negQ_q;
    negR_d   = negR_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start && isM) begin
          op_d   = op;
          hi_d   = '0;
          lo_d   = aMag;
          bMag_d = bMag;
          negQ_d = aNeg ^ bNeg;
          negR_d = aNeg;
          cnt_d  = '0;
          if (special) begin
            result_d = specVal;
            state_d  = S_DONE;
          end
`ifdef MULDIV_FAST_MUL_EN
          else if (!isDivOp) begin
            {hi_d, lo_d} = fastProd;
            negQ_d       = 1'b0;
            state_d      = S_FIX;
          end
`endif
          else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (isDivQ) begin
          if (!sum[XLEN+1]) hi_d = sum[XLEN-1:0];
          else              hi_d = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
          lo_d = {lo_q[XLEN-2:0], ~sum[XLEN+1]};
        end else begin
          hi_d = {carry, hiNew[XLEN-1:1]};
          lo_d = {hiNew[0], lo_q[XLEN-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(XLEN-1)) state_d = S_FIX;
      end
      S_FIX: begin
        case (op_q)
          MUL:                 result_d = prodFix[XLEN-1:0];
          MULH, MULHSU, MULHU: result_d = prodFix[2*XLEN-1:XLEN];
          DIV, DIVU:           result_d = negQ_q ? -lo_q : lo_q;
          REM, REMU:           result_d = negR_q ? -hi_q : hi_q;
          default:             result_d = result_q;
        endcase
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // An abort discards the in-flight op; DONE already shows its result so nothing is lost there.
    if (flush && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= NOP;
      hi_q     <= '0;
      lo_q     <= '0;
      bMag_q   <= '0;
      negQ_q   <= 1'b0;
      negR_q   <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      bMag_q   <= bMag_d;
      negQ_q   <= negQ_d;
      negR_q   <= negR_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed literal cases plus randomized ops
// compared every cycle against an arithmetic timing/result model (honours MULDIV_FAST_MUL_EN).
module tb_muldiv_sequencer;
  import alu_op_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  ALU_op_t     op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;

  int nTests = 0;
  int nFail  = 0;
  logic checkEn = 1'b0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MulLat = 2;
  localparam ALU_op_t FlushOp = DIVU;
`else
  localparam int MulLat = 34;
  localparam ALU_op_t FlushOp = MUL;
`endif

  always #5 clk = ~clk;

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .result(result)
  );

  function automatic bit isMOp(input ALU_op_t o);
    return o inside {MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU};
  endfunction

  function automatic bit isSpecial(input ALU_op_t o, input logic [31:0] x, input logic [31:0] y);
    if (!(o inside {DIV, DIVU, REM, REMU})) return 1'b0;
    if (y == 32'h0) return 1'b1;
    return (o inside {DIV, REM}) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] refOp(input ALU_op_t o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sa, sb, ua, ub, p;
    sa = {{32{x[31]}}, x};
    sb = {{32{y[31]}}, y};
    ua = {32'h0, x};
    ub = {32'h0, y};
    p  = 64'sd0;
    case (o)
      MUL:    begin p = sa * sb; return p[31:0];  end
      MULH:   begin p = sa * sb; return p[63:32]; end
      MULHSU: begin p = sa * ub; return p[63:32]; end
      MULHU:  begin p = ua * ub; return p[63:32]; end
      DIV:  begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (isSpecial(o, x, y)) return x;
        p = sa / sb; return p[31:0];
      end
      REM:  begin
        if (y == 0) return x;
        if (isSpecial(o, x, y)) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      DIVU: begin if (y == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
      REMU: begin if (y == 0) return x;             p = ua % ub; return p[31:0]; end
      default: return 32'h0;
    endcase
  endfunction

  function automatic int latency(input ALU_op_t o, input logic [31:0] x, input logic [31:0] y);
    if (isSpecial(o, x, y)) return 1;
    if (o inside {MUL, MULH, MULHSU, MULHU}) return MulLat;
    return 34;
  endfunction

  // Reference model: cycle index since accept, result appears only in the final (done) cycle.
  logic        mBusy = 1'b0, mDone = 1'b0;
  logic [31:0] mResult = 32'h0, mPend = 32'h0;
  int          mCycle = 0, mLat = 0;

  always @(posedge clk) begin
    if (rst) begin
      mBusy = 1'b0; mDone = 1'b0; mResult = 32'h0; mCycle = 0;
    end else if (!mBusy) begin
      mDone = 1'b0;
      if (start && isMOp(op)) begin
        mPend  = refOp(op, a, b);
        mLat   = latency(op, a, b);
        mCycle = 1;
        mBusy  = 1'b1;
        if (mLat == 1) begin mDone = 1'b1; mResult = mPend; end
      end
    end else if (mCycle == mLat || flush) begin
      mBusy = 1'b0; mDone = 1'b0; mCycle = 0;
    end else begin
      mCycle++;
      if (mCycle == mLat) begin mDone = 1'b1; mResult = mPend; end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("model busy", 32'(busy), 32'(mBusy));
      checkOutput("model done", 32'(done), 32'(mDone));
      checkOutput("model result", result, mResult);
    end
  end

  // Called at a negedge; returns at the negedge of cycle 1.
  task automatic applyStimulus(input ALU_op_t o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input int fromCyc, output int cyc);
    cyc = fromCyc;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic runOp(input string name, input ALU_op_t o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] exp, input int expCyc);
    int cyc;
    applyStimulus(o, x, y);
    waitDone(1, cyc);
    checkOutput({name, " result"}, result, exp);
    checkOutput({name, " done cycle"}, 32'(cyc), 32'(expCyc));
    checkOutput({name, " busy at done"}, 32'(busy), 32'h1);
    @(negedge clk);
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc, pulses, flushAt;
    logic [31:0] held;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = NOP; a = 32'h0; b = 32'h0;
    repeat (2) @(negedge clk);
    checkOutput("reset busy", 32'(busy), 32'h0);
    checkOutput("reset done", 32'(done), 32'h0);
    checkOutput("reset result", result, 32'h0);
    rst = 1'b0;
    checkEn = 1'b1;
    @(negedge clk);

    runOp("MUL 7*-3", MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MulLat);
    runOp("MULHU -1,-1", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MulLat);
    runOp("MULH -1,-1", MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MulLat);
    runOp("MULHSU -1,-1", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MulLat);
    runOp("DIV -7/2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    runOp("REM -7/2", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    runOp("DIVU", DIVU, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 34);
    runOp("REMU", REMU, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F, 34);
    runOp("DIVU by 0", DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    runOp("REMU by 0", REMU, 32'd5, 32'd0, 32'd5, 1);
    runOp("DIV ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    runOp("REM ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);

    held = result;
    applyStimulus(FlushOp, 32'd123, 32'd45);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush busy", 32'(busy), 32'h0);
    checkOutput("flush result held", result, held);
    pulses = 0;
    repeat (40) begin @(negedge clk); if (done) pulses++; end
    checkOutput("flush done pulses", 32'(pulses), 32'h0);

    applyStimulus(ADD, 32'd1, 32'd2);
    checkOutput("ADD ignored", 32'(busy), 32'h0);
    @(negedge clk);

    applyStimulus(DIVU, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    op = MUL; a = 32'd3; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(6, cyc);
    checkOutput("busy start ignored", result, 32'd14);
    checkOutput("busy start done cycle", 32'(cyc), 32'd34);
    op = MULHU; a = 32'd9; b = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("start in done cycle ignored", 32'(busy), 32'h0);

    flush = 1'b1;
    applyStimulus(REMU, 32'd17, 32'd5);
    flush = 1'b0;
    waitDone(1, cyc);
    checkOutput("idle flush start", result, 32'd2);
    checkOutput("idle flush done cycle", 32'(cyc), 32'd34);
    @(negedge clk);

    applyStimulus(DIV, 32'd1000, 32'd3);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid reset busy", 32'(busy), 32'h0);
    checkOutput("mid reset done", 32'(done), 32'h0);
    checkOutput("mid reset result", result, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int n = 0; n < 150; n++) begin
      int idx;
      idx = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 10)) : int'($urandom_range(11, 18));
      flushAt = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 36)) : 0;
      applyStimulus(ALU_op_t'(5'(idx)), pickOperand(), pickOperand());
      cyc = 1;
      while (busy && cyc < 100) begin
        if (cyc == flushAt) flush = 1'b1;
        if ($urandom_range(0, 15) == 0) begin
          op = ALU_op_t'(5'($urandom_range(11, 18))); a = $urandom; b = $urandom; start = 1'b1;
        end
        @(negedge clk);
        flush = 1'b0;
        start = 1'b0;
        cyc++;
      end
      if (cyc >= 100) checkOutput("random op timeout", 32'(busy), 32'h0);
    end

    checkEn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
